// File: rtl/disp_wr_arbiter_pkg.sv
// Shared types for the display-memory write arbiter: address/data words,
// the arbiter FSM state and the default requester count.
package disp_wr_arbiter_pkg;

  localparam int DISP_ADDR_W     = 10;
  localparam int DISP_DATA_W     = 8;
  localparam int DISP_WR_NUM_REQ = 3;

  typedef logic [DISP_ADDR_W-1:0] disp_addr_t;
  typedef logic [DISP_DATA_W-1:0] disp_data_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } disp_wr_state_t;

endpackage

// File: rtl/disp_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i+1 (wrapping) and
// grants the first valid requester. The pointer register lives in the parent.
module disp_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o
);

  logic found;
  int   cand;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_i) + i) % NUM_REQ;
      if (en_i && !found && valid_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/disp_wr_arbiter.sv
// Shares the display write port between NUM_REQ writers plus a clear
// sequencer. Define DISP_WR_VBLANK_ONLY_EN to restrict writes to a window after eof_i.
module disp_wr_arbiter
  import disp_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DISP_WR_NUM_REQ,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  input  disp_addr_t         req_addr_i [NUM_REQ],
  input  disp_data_t         req_data_i [NUM_REQ],
  input  logic               clear_i,
  input  disp_addr_t         clear_base_i,
  input  disp_addr_t         clear_len_i,
  input  disp_data_t         clear_data_i,
  output logic               clear_busy_o,
  output logic               clear_done_o,
  input  logic               eof_i,
  output logic               wr_en_o,
  output disp_addr_t         wr_addr_o,
  output disp_data_t         wr_data_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  disp_wr_state_t   state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  disp_addr_t       base_q, base_d;
  disp_addr_t       len_q, len_d;
  disp_data_t       fill_q, fill_d;
  disp_addr_t       k_q, k_d;
  logic             wr_en_q, wr_en_d;
  disp_addr_t       wr_addr_q, wr_addr_d;
  disp_data_t       wr_data_q, wr_data_d;
  logic             done_q, done_d;

  logic             window_open;
  logic             clear_start;
  logic             arb_en;
  logic [PTR_W-1:0] grant_idx;

`ifdef DISP_WR_VBLANK_ONLY_EN
  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  logic [WIN_W-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (eof_i)              win_d = WIN_W'(WINDOW_CYCLES);
    else if (win_q != '0)   win_d = win_q - WIN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  assign window_open = (win_q != '0);
`else
  logic unused_window;
  assign unused_window = eof_i ^ (WINDOW_CYCLES > 0);
  assign window_open   = 1'b1;
`endif

  // A clear request pre-empts any grant in the cycle it arrives.
  assign clear_start = (state_q == ARB) && clear_i && (clear_len_i != '0);
  assign arb_en      = (state_q == ARB) && window_open && !clear_start;

  disp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .valid_i     (req_valid_i),
    .ptr_i       (ptr_q),
    .en_i        (arb_en),
    .grant_o     (req_ready_o),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    base_d    = base_q;
    len_d     = len_q;
    fill_d    = fill_q;
    k_d       = k_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          base_d  = clear_base_i;
          len_d   = clear_len_i;
          fill_d  = clear_data_i;
          k_d     = '0;
          state_d = CLEAR;
        end else if (req_ready_o != '0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = req_addr_i[grant_idx];
          wr_data_d = req_data_i[grant_idx];
          ptr_d     = grant_idx;
        end
      end
      CLEAR: begin
        if (window_open) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + k_q;
          wr_data_d = fill_q;
          if (k_q == len_q - disp_addr_t'(1)) begin
            state_d = ARB;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + disp_addr_t'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      base_q    <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      k_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      base_q    <= base_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      k_q       <= k_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign clear_busy_o = (state_q == CLEAR);
  assign clear_done_o = done_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_disp_wr_arbiter.sv
// Directed self-checking bench for disp_wr_arbiter; the window tests are
// built only when DISP_WR_VBLANK_ONLY_EN is defined.
module tb_disp_wr_arbiter;
  import disp_wr_arbiter_pkg::*;

`ifdef DISP_WR_VBLANK_ONLY_EN
  localparam int TB_WIN = 3;
`else
  localparam int TB_WIN = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_valid_i;
  logic [2:0] req_ready_o;
  disp_addr_t req_addr_i [3];
  disp_data_t req_data_i [3];
  logic       clear_i;
  disp_addr_t clear_base_i;
  disp_addr_t clear_len_i;
  disp_data_t clear_data_i;
  logic       clear_busy_o;
  logic       clear_done_o;
  logic       eof_i;
  logic       wr_en_o;
  disp_addr_t wr_addr_o;
  disp_data_t wr_data_o;

  int checks = 0;
  int errors = 0;

  disp_wr_arbiter #(
    .NUM_REQ       (3),
    .WINDOW_CYCLES (TB_WIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .clear_i      (clear_i),
    .clear_base_i (clear_base_i),
    .clear_len_i  (clear_len_i),
    .clear_data_i (clear_data_i),
    .clear_busy_o (clear_busy_o),
    .clear_done_o (clear_done_o),
    .eof_i        (eof_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid_i  = '0;
    clear_i      = 1'b0;
    clear_base_i = '0;
    clear_len_i  = '0;
    clear_data_i = '0;
    eof_i        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr_i[i] = disp_addr_t'(10'h100 + i);
      req_data_i[i] = disp_data_t'(8'hA0 + i);
    end

    // Reset state
    step();
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_addr", 32'(wr_addr_o), 32'd0);
    check("rst_data", 32'(wr_data_o), 32'd0);
    check("rst_busy", 32'(clear_busy_o), 32'd0);
    check("rst_done", 32'(clear_done_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    do_reset();

`ifndef DISP_WR_VBLANK_ONLY_EN
    // Single requester
    req_addr_i[1]  = 10'h010;
    req_data_i[1]  = 8'h41;
    req_valid_i    = 3'b010;
    #1;
    check("single_ready", 32'(req_ready_o), 32'b010);
    step();
    req_valid_i = '0;
    check("single_wr_en", 32'(wr_en_o), 32'd1);
    check("single_addr", 32'(wr_addr_o), 32'h010);
    check("single_data", 32'(wr_data_o), 32'h41);
    step();
    check("single_once", 32'(wr_en_o), 32'd0);
    req_addr_i[1] = 10'h101;
    req_data_i[1] = 8'hA1;

    // Fairness: grant order 0,1,2,0,1,2
    do_reset();
    req_valid_i = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr_ready_%0d", c), 32'(req_ready_o), 32'(1 << (c % 3)));
      step();
      check($sformatf("rr_wr_en_%0d", c), 32'(wr_en_o), 32'd1);
      check($sformatf("rr_addr_%0d", c), 32'(wr_addr_o), 32'h100 + 32'(c % 3));
      check($sformatf("rr_data_%0d", c), 32'(wr_data_o), 32'hA0 + 32'(c % 3));
    end
    req_valid_i = '0;
    step();
    check("rr_idle", 32'(wr_en_o), 32'd0);

    // Clear across the top of the address space with req 0 held valid
    begin
      logic [9:0] exp_addr [4];
      exp_addr[0] = 10'h3FE;
      exp_addr[1] = 10'h3FF;
      exp_addr[2] = 10'h000;
      exp_addr[3] = 10'h001;
      req_valid_i  = 3'b001;
      clear_i      = 1'b1;
      clear_base_i = 10'h3FE;
      clear_len_i  = 10'd4;
      clear_data_i = 8'h20;
      #1;
      check("clr_start_ready", 32'(req_ready_o), 32'd0);
      step();
      clear_i = 1'b0;
      check("clr_busy_0", 32'(clear_busy_o), 32'd1);
      check("clr_ready_0", 32'(req_ready_o), 32'd0);
      check("clr_wr_en_0", 32'(wr_en_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("clr_wr_en_k%0d", k), 32'(wr_en_o), 32'd1);
        check($sformatf("clr_addr_k%0d", k), 32'(wr_addr_o), 32'(exp_addr[k]));
        check($sformatf("clr_data_k%0d", k), 32'(wr_data_o), 32'h20);
        check($sformatf("clr_done_k%0d", k), 32'(clear_done_o), 32'(k == 3));
        check($sformatf("clr_busy_k%0d", k), 32'(clear_busy_o), 32'(k != 3));
        check($sformatf("clr_ready_k%0d", k), 32'(req_ready_o), (k == 3) ? 32'b001 : 32'd0);
      end
      step();
      req_valid_i = '0;
      check("clr_after_wr_en", 32'(wr_en_o), 32'd1);
      check("clr_after_addr", 32'(wr_addr_o), 32'h100);
      check("clr_after_done", 32'(clear_done_o), 32'd0);
    end

    // Clear collides with req 2
    req_valid_i  = 3'b100;
    clear_i      = 1'b1;
    clear_base_i = 10'h050;
    clear_len_i  = 10'd2;
    clear_data_i = 8'h55;
    #1;
    check("col_ready", 32'(req_ready_o), 32'd0);
    step();
    clear_i = 1'b0;
    check("col_busy", 32'(clear_busy_o), 32'd1);
    step();
    check("col_wr0_addr", 32'(wr_addr_o), 32'h050);
    step();
    check("col_wr1_addr", 32'(wr_addr_o), 32'h051);
    check("col_done", 32'(clear_done_o), 32'd1);
    check("col_ready_after", 32'(req_ready_o), 32'b100);
    step();
    req_valid_i = '0;
    check("col_req2_wr_en", 32'(wr_en_o), 32'd1);
    check("col_req2_addr", 32'(wr_addr_o), 32'h102);
    check("col_req2_data", 32'(wr_data_o), 32'hA2);

    // Zero-length clear is ignored
    clear_i     = 1'b1;
    clear_len_i = 10'd0;
    step();
    clear_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("len0_busy_%0d", c), 32'(clear_busy_o), 32'd0);
      check($sformatf("len0_wr_en_%0d", c), 32'(wr_en_o), 32'd0);
      check($sformatf("len0_done_%0d", c), 32'(clear_done_o), 32'd0);
      step();
    end

    // Reset after 2 of 8 clear writes
    clear_i      = 1'b1;
    clear_base_i = 10'h200;
    clear_len_i  = 10'd8;
    clear_data_i = 8'h77;
    step();
    clear_i = 1'b0;
    step();
    step();
    check("rmc_wr1_addr", 32'(wr_addr_o), 32'h201);
    rst_n = 1'b0;
    #1;
    check("rmc_wr_en", 32'(wr_en_o), 32'd0);
    check("rmc_addr", 32'(wr_addr_o), 32'd0);
    check("rmc_data", 32'(wr_data_o), 32'd0);
    check("rmc_busy", 32'(clear_busy_o), 32'd0);
    check("rmc_done", 32'(clear_done_o), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rmc_no_done_%0d", c), 32'(clear_done_o), 32'd0);
      check($sformatf("rmc_idle_%0d", c), 32'(wr_en_o), 32'd0);
    end
    req_valid_i = 3'b111;
    #1;
    check("rmc_first_ready", 32'(req_ready_o), 32'b001);
    step();
    req_valid_i = '0;
    check("rmc_first_addr", 32'(wr_addr_o), 32'h100);
`else
    // Window closed before the first eof_i
    req_valid_i = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("win_closed_ready_%0d", c), 32'(req_ready_o), 32'd0);
      step();
      check($sformatf("win_closed_wr_%0d", c), 32'(wr_en_o), 32'd0);
    end
    eof_i = 1'b1;
    #1;
    check("win_eof_ready", 32'(req_ready_o), 32'd0);
    step();
    eof_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("win_ready_%0d", c), 32'(req_ready_o), (c < 3) ? 32'b001 : 32'd0);
      step();
      check($sformatf("win_wr_%0d", c), 32'(wr_en_o), (c < 3) ? 32'd1 : 32'd0);
    end
    req_valid_i = '0;

    // Five-word clear spanning two windows
    begin
      int writes   = 0;
      int done_cyc = -1;
      int dones    = 0;
      clear_i      = 1'b1;
      clear_base_i = 10'h300;
      clear_len_i  = 10'd5;
      clear_data_i = 8'h11;
      step();
      clear_i = 1'b0;
      for (int c = 0; c < 30; c++) begin
        eof_i = (c == 2) || (c == 12);
        step();
        if (wr_en_o) begin
          check($sformatf("wclr_addr_%0d", writes), 32'(wr_addr_o), 32'h300 + 32'(writes));
          writes++;
        end
        if (clear_done_o) begin
          dones++;
          done_cyc = c;
        end
        if (c == 10) check("wclr_stall_busy", 32'(clear_busy_o), 32'd1);
        if (c == 10) check("wclr_stall_writes", 32'(writes), 32'd3);
      end
      eof_i = 1'b0;
      check("wclr_writes", 32'(writes), 32'd5);
      check("wclr_dones", 32'(dones), 32'd1);
      check("wclr_done_late", 32'(done_cyc > 12), 32'd1);
      check("wclr_busy_end", 32'(clear_busy_o), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_wr_arbiter.md
Name: disp_wr_arbiter

Overview:
- Shares the single display-memory write port of video_main (wr_en/addr/data) between NUM_REQ independent writers, e.g. video_test, a text console and a host bridge.
- Adds a built-in clear sequencer that fills an address range with a constant value.
- Sits between the writers and video_main's display_wr_* inputs.
- Round-robin fairness; at most one write per clock.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- WINDOW_CYCLES, 1024: write-window length after eof_i. Used only with DISP_WR_VBLANK_ONLY_EN.

Ports:
- clk  in  1  design clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester write request
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr_i  in  NUM_REQ x disp_addr_t  per-requester address
- req_data_i  in  NUM_REQ x disp_data_t  per-requester data
- clear_i  in  1  start-clear pulse
- clear_base_i  in  disp_addr_t  first address to clear
- clear_len_i  in  disp_addr_t  number of words to clear
- clear_data_i  in  disp_data_t  fill value
- clear_busy_o  out  1  clear in progress
- clear_done_o  out  1  one-cycle pulse after the last clear write
- eof_i  in  1  end-of-frame pulse from video_main
- wr_en_o  out  1  display write enable
- wr_addr_o  out  disp_addr_t  display write address
- wr_data_o  out  disp_data_t  display write data

Behaviour:
- Reset: every output is 0. The round-robin pointer resets to NUM_REQ-1, so requester 0 wins first. FSM enters ARB. Reset mid-clear aborts the clear and produces no clear_done_o.
- Handshake:
  - Requester i is accepted on a clock where req_valid_i[i] && req_ready_o[i].
  - valid, addr and data must hold stable until accepted.
  - req_ready_o is combinational from valid, pointer, state and window; never from the requester's own ready.
- Latency: an accept at cycle N gives wr_en_o=1 with that addr/data at N+1. wr_en_o is 0 on cycles with no accept or clear write.
- Round-robin:
  - Search starts at pointer+1 and wraps modulo NUM_REQ.
  - The first valid requester found is granted.
  - On accept, the pointer becomes the granted index. With no accept, the pointer is unchanged.
- FSM states: ARB, CLEAR.
  - ARB: grants as above. clear_i=1 with clear_len_i!=0 latches base, len and data and moves to CLEAR next cycle. That same cycle no grant is issued: clear wins over simultaneous requests.
  - clear_i with clear_len_i==0 is ignored: no busy, no done.
  - CLEAR: clear_busy_o=1; all req_ready_o=0. Each cycle issues one write (addr=base+k, data=fill; wr_en_o the next cycle) for k=0..len-1.
  - Address arithmetic wraps modulo 2^$bits(disp_addr_t).
  - After the write for k=len-1 is issued, return to ARB. clear_done_o pulses on the cycle the final wr_en_o is high.
  - clear_busy_o falls on that same cycle.
  - clear_i during CLEAR is ignored.
- Requester data is never dropped or duplicated. Each accept produces exactly one write.

Optional Feature:
- Macro: DISP_WR_VBLANK_ONLY_EN.
- Defined:
  - An internal window counter loads WINDOW_CYCLES on eof_i and decrements to 0. The window is open while the counter is nonzero.
  - When closed, req_ready_o=0 and the CLEAR FSM stalls: k holds, no write is issued, clear_busy_o stays 1.
  - eof_i while the window is open reloads the counter.
  - Reset clears the counter, so the window is closed until the first eof_i.
- Undefined: the window is always open and eof_i is unused (consumed via an unused_ signal).

Decomposition:
- Shared package (video_package.svh):
  - disp_wr_state_t enum {ARB, CLEAR}.
  - DISP_WR_NUM_REQ default.
  - disp_addr_t and disp_data_t are already defined there.
- One sub-module, disp_rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: valid vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single requester: req 1 valid with addr 0x010, data 0x41 → ready the same cycle. Next cycle wr_en_o=1, addr 0x010, data 0x41. Exactly one write.
- Fairness: all 3 valid continuously for 6 cycles after reset → grant order 0,1,2,0,1,2. wr_en_o high for 6 consecutive cycles.
- Clear: base=0x3FE, len=4, fill=0x20 on a 10-bit address → writes to 0x3FE, 0x3FF, 0x000, 0x001. busy high for 4 cycles. clear_done_o on the 4th write. No grants meanwhile, even with req 0 held valid.
- Collision and edge cases:
  - clear_i in the same cycle as req 2 valid → no grant that cycle; req 2 accepted on the first ARB cycle after the clear.
  - clear_len_i=0 → no writes, busy stays 0.
- Reset mid-clear: rst_n low after 2 of 8 clear writes → all outputs 0 immediately, no clear_done_o. After release, req 0 wins first.
- With DISP_WR_VBLANK_ONLY_EN and WINDOW_CYCLES=3:
  - Request before any eof_i → held, no ready.
  - After eof_i, accepts occur only on the 3 window cycles.
  - A 5-word clear spanning two frames completes after the second eof_i.
